// File: rtl/rf_write_ctrl_pkg.sv
// Shared definitions for the register-file write controller: default widths
// (aliased to the core's global defines), the result entry layout and a small
// sizing helper used by the interface and the modules.
`ifndef REG_LENGTH_IN_INST
`define REG_LENGTH_IN_INST 5
`endif
`ifndef INST_BUS_LENGTH
`define INST_BUS_LENGTH 32
`endif
`ifndef REG_NUMBER
`define REG_NUMBER 32
`endif

package rf_write_ctrl_pkg;

  localparam int RF_ADDR_W = `REG_LENGTH_IN_INST;
  localparam int RF_DATA_W = `INST_BUS_LENGTH;
  localparam int RF_NREG   = `REG_NUMBER;
  localparam int WB_DEPTH  = 4;

  // Result entry as stored in the write-back FIFO: destination in the upper
  // bits, value in the lower bits.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rf_write_ctrl_if.sv
// Bundle of the issue-side hazard port, the result push port and the register
// file write port. The controller is the slave; the surrounding pipeline
// (issue stage, result producers, register file) is the master.
interface rf_write_ctrl_if
  import rf_write_ctrl_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = WB_DEPTH
) ();

  localparam int CNT_W = cnt_w(DEPTH);

  logic              issue_valid_i;
  logic [ADDR_W-1:0] issue_dst_i;
  logic              issue_wr_i;
  logic [ADDR_W-1:0] issue_src1_i;
  logic [ADDR_W-1:0] issue_src2_i;
  logic              stall_o;

  logic              res_valid_i;
  logic [ADDR_W-1:0] res_reg_i;
  logic [DATA_W-1:0] res_data_i;
  logic              res_ready_o;

  logic              rf_busy_i;
  logic              regWrite_o;
  logic [ADDR_W-1:0] reg3_o;
  logic [DATA_W-1:0] data3_o;

  logic [CNT_W-1:0]  count_o;
  logic              err_o;

  modport slave (
    input  issue_valid_i, issue_dst_i, issue_wr_i, issue_src1_i, issue_src2_i,
    output stall_o,
    input  res_valid_i, res_reg_i, res_data_i,
    output res_ready_o,
    input  rf_busy_i,
    output regWrite_o, reg3_o, data3_o,
    output count_o, err_o
  );

  modport master (
    output issue_valid_i, issue_dst_i, issue_wr_i, issue_src1_i, issue_src2_i,
    input  stall_o,
    output res_valid_i, res_reg_i, res_data_i,
    input  res_ready_o,
    output rf_busy_i,
    input  regWrite_o, reg3_o, data3_o,
    input  count_o, err_o
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for completed results. Full/empty come from the
// occupancy count; a push while full is dropped even if a pop happens in the
// same cycle, so there is no pass-through path. The head entry is exposed
// combinationally for the write port.
module wb_fifo
  import rf_write_ctrl_pkg::*;
#(
  parameter int W     = RF_ADDR_W + RF_DATA_W,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    push_i,
  input  logic [W-1:0]            din_i,
  input  logic                    pop_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [cnt_w(DEPTH)-1:0] count_o,
  output logic [W-1:0]            head_o
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/rf_write_ctrl.sv
// Writer-side controller for the register file's single write port. Results
// are queued in order and retired one per cycle when the port is free; a
// per-register pending scoreboard stalls the issue stage on RAW and WAW
// hazards until the corresponding write has landed.
module rf_write_ctrl
  import rf_write_ctrl_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  parameter int NREG   = RF_NREG,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  rf_write_ctrl_if.slave bus
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = cnt_w(DEPTH);

  logic [NREG-1:0]    pend_q;
  logic [NREG-1:0]    pend_d;
  logic               err_q;

  logic               push;
  logic               retire;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic [ADDR_W-1:0]  head_reg;
  logic [DATA_W-1:0]  head_data;
  logic               head_nz;

  logic               stall;
  logic               issue_acc;
  logic               issue_set;

  wb_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .din_i   ({bus.res_reg_i, bus.res_data_i}),
    .pop_i   (retire),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );

  assign head_reg  = head[ENTRY_W-1 -: ADDR_W];
  assign head_data = head[DATA_W-1:0];
  assign head_nz   = (head_reg != '0);

  // Result side: accept whenever there is room; retire whenever the port is ours.
  assign push   = bus.res_valid_i & ~full;
  assign retire = ~empty & ~bus.rf_busy_i;

  // Hazard check: any pending source (RAW) or a pending destination (WAW).
  assign stall = bus.issue_valid_i &
                 (pend_q[bus.issue_src1_i] | pend_q[bus.issue_src2_i] |
                  (bus.issue_wr_i & pend_q[bus.issue_dst_i]));

  assign issue_acc = bus.issue_valid_i & ~stall;
  assign issue_set = issue_acc & bus.issue_wr_i & (bus.issue_dst_i != '0);

  // Next pending vector: clear on retire, set on accepted writing issue.
  // WAW stalling guarantees the two never target the same register.
  always_comb begin
    pend_d = pend_q;
    if (retire && head_nz) pend_d[head_reg] = 1'b0;
    if (issue_set)         pend_d[bus.issue_dst_i] = 1'b1;
  end

  // Scoreboard state and the sticky unexpected-result flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (retire && head_nz && !pend_q[head_reg]) err_q <= 1'b1;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.res_ready_o = ~full;
  assign bus.regWrite_o  = retire & head_nz;
  assign bus.reg3_o      = empty ? '0 : head_reg;
  assign bus.data3_o     = empty ? '0 : head_data;
  assign bus.count_o     = count;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Bench for rf_write_ctrl: expected register-file writes go into a queue when
// a result is driven; a monitor pops and compares on every observed write.
module tb_rf_write_ctrl;
  import rf_write_ctrl_pkg::*;

  logic clk_i;
  logic rst_n_i;

  int n_checks;
  int n_fail;

  wb_entry_t exp_q[$];

  rf_write_ctrl_if #(.ADDR_W(RF_ADDR_W), .DATA_W(RF_DATA_W), .DEPTH(4)) bus ();

  rf_write_ctrl #(
    .ADDR_W (RF_ADDR_W),
    .DATA_W (RF_DATA_W),
    .NREG   (RF_NREG),
    .DEPTH  (4)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_issue(input logic v, input logic [4:0] dst, input logic wr,
                             input logic [4:0] s1, input logic [4:0] s2);
    bus.issue_valid_i = v;
    bus.issue_dst_i   = dst;
    bus.issue_wr_i    = wr;
    bus.issue_src1_i  = s1;
    bus.issue_src2_i  = s2;
  endtask

  task automatic drive_res(input logic [4:0] r, input logic [31:0] d, input bit enq);
    wb_entry_t e;
    bus.res_valid_i = 1'b1;
    bus.res_reg_i   = r;
    bus.res_data_i  = d;
    e.rd   = r;
    e.data = d;
    if (enq) exp_q.push_back(e);
  endtask

  // Monitor: every write on the register-file port must match the queue head.
  always @(negedge clk_i) begin
    if (bus.regWrite_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", {27'd0, bus.reg3_o}, 64'hFFFF);
      end else begin
        wb_entry_t e;
        e = exp_q.pop_front();
        check_val("wr_reg", bus.reg3_o, e.rd);
        check_val("wr_data", bus.data3_o, e.data);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n_i  = 1'b1;
    drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    bus.res_valid_i = 1'b0;
    bus.res_reg_i   = '0;
    bus.res_data_i  = '0;
    bus.rf_busy_i   = 1'b0;

    // Reset state
    #2 rst_n_i = 1'b0;
    #1;
    check_val("rst_count", bus.count_o, 0);
    check_val("rst_ready", bus.res_ready_o, 1);
    check_val("rst_stall", bus.stall_o, 0);
    check_val("rst_regwrite", bus.regWrite_o, 0);
    check_val("rst_reg3", bus.reg3_o, 0);
    check_val("rst_data3", bus.data3_o, 0);
    check_val("rst_err", bus.err_o, 0);
    #9 rst_n_i = 1'b1;
    tick();

    // RAW on r5
    drive_issue(1'b1, 5'd5, 1'b1, 5'd0, 5'd0);
    #1 check_val("raw_issue_ok", bus.stall_o, 0);
    tick();
    drive_issue(1'b1, 5'd0, 1'b0, 5'd5, 5'd0);
    drive_res(5'd5, 32'hDEADBEEF, 1'b1);
    #1 check_val("raw_stall", bus.stall_o, 1);
    tick();
    bus.res_valid_i = 1'b0;
    #1;
    check_val("raw_wr_en", bus.regWrite_o, 1);
    check_val("raw_reg3", bus.reg3_o, 5);
    check_val("raw_data3", bus.data3_o, 32'hDEADBEEF);
    check_val("raw_still_stall", bus.stall_o, 1);
    tick();
    check_val("raw_released", bus.stall_o, 0);
    tick();
    drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

    // WAW on r7
    drive_issue(1'b1, 5'd7, 1'b1, 5'd0, 5'd0);
    #1 check_val("waw_first_ok", bus.stall_o, 0);
    tick();
    bus.rf_busy_i = 1'b1;
    drive_res(5'd7, 32'h00000077, 1'b1);
    #1 check_val("waw_stall", bus.stall_o, 1);
    tick();
    bus.res_valid_i = 1'b0;
    #1;
    check_val("waw_busy_nowrite", bus.regWrite_o, 0);
    check_val("waw_count1", bus.count_o, 1);
    check_val("waw_stall_busy", bus.stall_o, 1);
    tick();
    bus.rf_busy_i = 1'b0;
    #1 check_val("waw_wr_en", bus.regWrite_o, 1);
    tick();
    check_val("waw_released", bus.stall_o, 0);
    tick();
    drive_issue(1'b1, 5'd0, 1'b0, 5'd7, 5'd0);
    #1 check_val("waw_repend", bus.stall_o, 1);
    drive_res(5'd7, 32'h00001234, 1'b1);
    tick();
    bus.res_valid_i = 1'b0;
    tick();
    check_val("waw_clear2", bus.stall_o, 0);
    drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();

    // Fill the FIFO while the port is busy
    for (int i = 0; i < 5; i++) begin
      logic [4:0] d;
      d = (i == 4) ? 5'd6 : 5'(i + 1);
      drive_issue(1'b1, d, 1'b1, 5'd0, 5'd0);
      tick();
    end
    drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    bus.rf_busy_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_res(5'(i), 32'h100 + 32'(i), 1'b1);
      tick();
    end
    drive_res(5'd6, 32'h606, 1'b1);
    #1;
    check_val("fill_count4", bus.count_o, 4);
    check_val("fill_not_ready", bus.res_ready_o, 0);
    tick();
    check_val("fill_hold", bus.count_o, 4);
    bus.rf_busy_i = 1'b0;
    #1;
    check_val("fill_drain_wr", bus.regWrite_o, 1);
    check_val("fill_no_passthru", bus.res_ready_o, 0);
    tick();
    check_val("fill_count3", bus.count_o, 3);
    check_val("fill_ready", bus.res_ready_o, 1);
    tick();
    bus.res_valid_i = 1'b0;
    #1;
    check_val("fill_count_same", bus.count_o, 3);
    tick();
    tick();
    check_val("fill_tail_reg", bus.reg3_o, 6);
    tick();
    check_val("fill_empty", bus.count_o, 0);
    check_val("fill_no_err", bus.err_o, 0);

    // r0 is never pending and its result is dropped silently
    drive_issue(1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    #1 check_val("r0_issue", bus.stall_o, 0);
    tick();
    check_val("r0_not_pending", bus.stall_o, 0);
    drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    drive_res(5'd0, 32'h0000AAAA, 1'b0);
    tick();
    bus.res_valid_i = 1'b0;
    #1;
    check_val("r0_count", bus.count_o, 1);
    check_val("r0_no_write", bus.regWrite_o, 0);
    check_val("r0_head_data", bus.data3_o, 32'h0000AAAA);
    tick();
    check_val("r0_popped", bus.count_o, 0);
    check_val("r0_no_err", bus.err_o, 0);

    // Result for a register that was never issued
    drive_res(5'd9, 32'h99999999, 1'b1);
    tick();
    bus.res_valid_i = 1'b0;
    #1;
    check_val("err_write_en", bus.regWrite_o, 1);
    check_val("err_not_yet", bus.err_o, 0);
    tick();
    check_val("err_set", bus.err_o, 1);
    tick();
    tick();
    check_val("err_sticky", bus.err_o, 1);
    rst_n_i = 1'b0;
    #1 check_val("err_cleared", bus.err_o, 0);
    rst_n_i = 1'b1;
    tick();

    // Asynchronous reset with entries queued and r3 pending
    drive_issue(1'b1, 5'd3, 1'b1, 5'd0, 5'd0);
    tick();
    drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    bus.rf_busy_i = 1'b1;
    drive_res(5'd3, 32'h3, 1'b0);
    tick();
    drive_res(5'd10, 32'hA, 1'b0);
    tick();
    drive_res(5'd11, 32'hB, 1'b0);
    tick();
    bus.res_valid_i = 1'b0;
    #1 check_val("ar_count3", bus.count_o, 3);
    drive_issue(1'b1, 5'd0, 1'b0, 5'd3, 5'd0);
    #1 check_val("ar_stall_pre", bus.stall_o, 1);
    bus.rf_busy_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    check_val("ar_count0", bus.count_o, 0);
    check_val("ar_no_write", bus.regWrite_o, 0);
    check_val("ar_no_stall", bus.stall_o, 0);
    check_val("ar_ready", bus.res_ready_o, 1);
    drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    rst_n_i = 1'b1;
    tick();
    tick();
    check_val("ar_still_empty", bus.count_o, 0);
    check_val("ar_still_no_write", bus.regWrite_o, 0);

    check_val("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_ctrl.md
Name: rf_write_ctrl

Overview:
- Writer-side controller for the register file's single write port; it drives regWrite/reg3/data3.
- Accepts completed results from the execute and memory stages into a small in-order FIFO.
- Retires at most one result per cycle onto the register file.
- Keeps a per-register pending scoreboard, so the issue stage stalls on read-after-write and write-after-write hazards until the write has landed.

Parameters:
- ADDR_W, 5, register index width (`REG_LENGTH_IN_INST).
- DATA_W, 32, data width (`INST_BUS_LENGTH).
- NREG, 32, number of registers (`REG_NUMBER).
- DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- issue_valid_i  in  1  issue stage presents an instruction.
- issue_dst_i  in  ADDR_W  destination register of the issuing instruction.
- issue_wr_i  in  1  the issuing instruction writes issue_dst_i.
- issue_src1_i  in  ADDR_W  first source register.
- issue_src2_i  in  ADDR_W  second source register.
- stall_o  out  1  hazard stall; the issue is not accepted this cycle.
- res_valid_i  in  1  result offered.
- res_reg_i  in  ADDR_W  result destination register.
- res_data_i  in  DATA_W  result value.
- res_ready_o  out  1  FIFO can accept a result.
- rf_busy_i  in  1  another agent owns the write port this cycle; do not retire.
- regWrite_o  out  1  register file write enable.
- reg3_o  out  ADDR_W  register file write index.
- data3_o  out  DATA_W  register file write data.
- count_o  out  clog2(DEPTH)+1  FIFO occupancy.
- err_o  out  1  sticky flag: a result arrived for a non-pending register.

Behaviour:
- Reset (async assert, sync-safe release):
  - FIFO empty; count_o=0.
  - All pending bits 0.
  - err_o=0, regWrite_o=0, reg3_o=0, data3_o=0, res_ready_o=1, stall_o=0.
- Hazard check (combinational):
  - stall_o = issue_valid_i & (pend[src1] | pend[src2] | (issue_wr_i & pend[dst])).
  - Register 0 is never pending.
- Issue accept:
  - Accepted when issue_valid_i & !stall_o.
  - If issue_wr_i and dst != 0, pend[dst] is set at that edge.
- Result push:
  - Occurs when res_valid_i & res_ready_o; res_ready_o = (count < DEPTH).
  - There is no pass-through when full, even if a retire happens the same cycle.
- Retire:
  - Occurs when the FIFO is not empty and rf_busy_i == 0.
  - regWrite_o, reg3_o and data3_o are driven combinationally from the FIFO head; regWrite_o = !empty & !rf_busy_i & (head.reg != 0).
  - At that edge the head is popped and pend[head.reg] is cleared.
  - A head entry for r0 is popped silently with regWrite_o=0.
  - When not retiring, reg3_o/data3_o still show the head (or 0 when empty); only regWrite_o qualifies them.
- Latency:
  - A result pushed at edge N is visible on the write port during cycle N+1 and written to the register file at edge N+1.
  - The pending bit also clears at edge N+1, so a dependent issue is accepted at edge N+2 or later, and its combinational read returns the new value.
- Simultaneous push and retire: count is unchanged; ordering is strictly FIFO.
- Simultaneous set and clear of the same register cannot occur: an issue to a pending dst is stalled by the WAW term. Any other mix of set/clear on different bits is applied independently.
- err_o:
  - Set when a retired head.reg (nonzero) has pend=0.
  - The write still occurs.
  - Cleared only by reset.
- Pointers: wrap modulo DEPTH; full/empty are derived from count, not from pointer compare.
- Reset mid-operation: all queued results are discarded and all pending bits are cleared; no partial write is emitted after the reset assertion.

Decomposition:
- Shared package/defines hold:
  - ADDR_W/DATA_W/NREG defaults, aliased to the existing `REG_LENGTH_IN_INST, `INST_BUS_LENGTH and `REG_NUMBER.
  - The FIFO entry layout {reg, data}.
- One sub-module, wb_fifo: a parameterised synchronous FIFO with push/pop/count/head outputs and no pass-through.
- The scoreboard and hazard logic stay in rf_write_ctrl.

Test Plan:
- Issue dst=5 with src1=src2=0 is accepted. Next cycle, issue src1=5 -> stall_o=1. Push res reg=5, data=0xDEADBEEF -> next cycle regWrite_o=1, reg3_o=5, data3_o=0xDEADBEEF; the following cycle stall_o=0.
- WAW: with r7 pending, issue dst=7 -> stall_o=1 until the r7 result retires; then accepted and pend[7] set again.
- Fill: hold rf_busy_i=1 and push 4 results (r1..r4) -> count_o=4, res_ready_o=0. A 5th result held on res_valid_i is not taken. Release busy -> writes r1,r2,r3,r4 on 4 consecutive cycles; the 5th is accepted in the first cycle count<4.
- r0: issue dst=0 -> no pending bit; push res reg=0 -> popped with regWrite_o=0, no error.
- Unissued result: push res reg=9 with pend[9]=0 -> write occurs and err_o=1 stays set. Reset -> err_o=0.
- Async reset asserted with 3 entries queued and r3 pending -> count_o=0, regWrite_o=0, stall_o=0 immediately, with no clock edge required.
